// File: rtl/coin_payout.sv
`default_nettype none
// ============================================================================
// Module   : coin_payout
// Function : Change/refund payout controller; ejects 1-leu coins first, then
//            50-bani coins, and reports any residual it could not pay.
// Revision : 1.0
// ============================================================================
module coin_payout #(
   parameter int AMT_W     = 4,
   parameter int PULSE_LEN = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   input  logic [AMT_W-1:0] req_amount,
   output logic             req_ready,
   input  logic             mech_busy,
   input  logic             empty_1leu,
   input  logic             empty_50bani,
   output logic             eject_1leu,
   output logic             eject_50bani,
   output logic             done,
   output logic             short,
   output logic [AMT_W-1:0] remaining
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SELECT = 3'd1,
      S_EJECT  = 3'd2,
      S_SETTLE = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   localparam logic [3:0] c_pulse_last = 4'(PULSE_LEN - 1);

   state_t           r_state, w_state_nxt;
   logic [AMT_W-1:0] r_remaining, w_remaining_nxt;
   logic             r_short, w_short_nxt;
   logic             r_eject_1leu, w_eject_1leu_nxt;
   logic             r_eject_50bani, w_eject_50bani_nxt;
   logic [3:0]       r_pulse_cnt, w_pulse_cnt_nxt;
   logic             w_ge2, w_ge1;

   assign w_ge2 = |r_remaining[AMT_W-1:1];
   assign w_ge1 = |r_remaining;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_remaining    <= '0;
         r_short        <= 1'b0;
         r_eject_1leu   <= 1'b0;
         r_eject_50bani <= 1'b0;
         r_pulse_cnt    <= '0;
      end else begin
         r_state        <= w_state_nxt;
         r_remaining    <= w_remaining_nxt;
         r_short        <= w_short_nxt;
         r_eject_1leu   <= w_eject_1leu_nxt;
         r_eject_50bani <= w_eject_50bani_nxt;
         r_pulse_cnt    <= w_pulse_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt        = r_state;
      w_remaining_nxt    = r_remaining;
      w_short_nxt        = r_short;
      w_eject_1leu_nxt   = r_eject_1leu;
      w_eject_50bani_nxt = r_eject_50bani;
      w_pulse_cnt_nxt    = r_pulse_cnt;
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               w_remaining_nxt = req_amount;
               w_short_nxt     = 1'b0;
               w_state_nxt     = S_SELECT;
            end
         end
         S_SELECT: begin
            // The amount is debited on the same edge the pulse starts.
            if (w_ge2 && !empty_1leu) begin
               if (!mech_busy) begin
                  w_eject_1leu_nxt = 1'b1;
                  w_remaining_nxt  = r_remaining - AMT_W'(2);
                  w_pulse_cnt_nxt  = '0;
                  w_state_nxt      = S_EJECT;
               end
            end else if (w_ge1 && !empty_50bani) begin
               if (!mech_busy) begin
                  w_eject_50bani_nxt = 1'b1;
                  w_remaining_nxt    = r_remaining - AMT_W'(1);
                  w_pulse_cnt_nxt    = '0;
                  w_state_nxt        = S_EJECT;
               end
            end else begin
               w_short_nxt = w_ge1;
               w_state_nxt = S_DONE;
            end
         end
         S_EJECT: begin
            if (r_pulse_cnt == c_pulse_last) begin
               w_eject_1leu_nxt   = 1'b0;
               w_eject_50bani_nxt = 1'b0;
               w_pulse_cnt_nxt    = '0;
               w_state_nxt        = S_SETTLE;
            end else begin
               w_pulse_cnt_nxt = r_pulse_cnt + 4'd1;
            end
         end
         S_SETTLE: w_state_nxt = S_SELECT;
         S_DONE:   w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   assign req_ready    = (r_state == S_IDLE);
   assign done         = (r_state == S_DONE);
   assign eject_1leu   = r_eject_1leu;
   assign eject_50bani = r_eject_50bani;
   assign short        = r_short;
   assign remaining    = r_remaining;

endmodule
`default_nettype wire

// File: tb/tb_coin_payout.sv
`default_nettype none
// ============================================================================
// Module   : tb_coin_payout
// Function : Directed and randomized payouts against a timeline model of the
//            coin payout controller.
// Revision : 1.0
// ============================================================================
module tb_coin_payout;

   localparam int AMT_W = 4;
   localparam int P     = 4;
   localparam int NC    = 640;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             req_valid = 1'b0;
   logic [AMT_W-1:0] req_amount = '0;
   logic             req_ready;
   logic             mech_busy = 1'b0;
   logic             empty_1leu = 1'b0;
   logic             empty_50bani = 1'b0;
   logic             eject_1leu;
   logic             eject_50bani;
   logic             done;
   logic             short;
   logic [AMT_W-1:0] remaining;

   int n_checks = 0;
   int n_pass   = 0;

   bit busy   [NC];
   bit exp_e1 [NC];
   bit exp_e50[NC];
   int exp_done;
   bit exp_short;
   int exp_rem;

   coin_payout #(.AMT_W(AMT_W), .PULSE_LEN(P)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_amount  (req_amount),
      .req_ready   (req_ready),
      .mech_busy   (mech_busy),
      .empty_1leu  (empty_1leu),
      .empty_50bani(empty_50bani),
      .eject_1leu  (eject_1leu),
      .eject_50bani(eject_50bani),
      .done        (done),
      .short       (short),
      .remaining   (remaining)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Payout timeline: cycle 1 is the first SELECT after the accept edge.
   task automatic model(input int amt, input bit e1, input bit e50);
      int rem, t, coin;
      for (int i = 0; i < NC; i++) begin
         exp_e1[i]  = 1'b0;
         exp_e50[i] = 1'b0;
      end
      rem = amt;
      t   = 1;
      while (1) begin
         if (rem >= 2 && !e1)       coin = 2;
         else if (rem >= 1 && !e50) coin = 1;
         else break;
         while (busy[t]) t++;
         for (int k = 1; k <= P; k++) begin
            if (coin == 2) exp_e1[t+k]  = 1'b1;
            else           exp_e50[t+k] = 1'b1;
         end
         rem -= coin;
         t   += P + 2;
      end
      exp_done  = t + 1;
      exp_short = (rem != 0);
      exp_rem   = rem;
   endtask

   task automatic clear_busy();
      for (int i = 0; i < NC; i++) busy[i] = 1'b0;
   endtask

   task automatic run_payout(input string tag, input int amt, input bit e1, input bit e50,
                             input int glitch);
      empty_1leu   = e1;
      empty_50bani = e50;
      model(amt, e1, e50);
      @(negedge clk);
      req_valid  = 1'b1;
      req_amount = amt[AMT_W-1:0];
      mech_busy  = 1'b0;
      @(posedge clk);
      for (int c = 1; c <= exp_done + 1; c++) begin
         #1;
         req_valid  = (c == glitch);
         req_amount = 4'hF;
         mech_busy  = busy[c];
         @(negedge clk);
         check({tag, " rdy/e1/e50/done"}, {28'd0, req_ready, eject_1leu, eject_50bani, done},
               {28'd0, (c > exp_done), exp_e1[c], exp_e50[c], (c == exp_done)});
         if (c == exp_done) begin
            check({tag, " short"}, {31'd0, short}, {31'd0, exp_short});
            check({tag, " remaining"}, {28'd0, remaining}, exp_rem);
         end
         @(posedge clk);
      end
      req_valid = 1'b0;
      mech_busy = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst ready", {31'd0, req_ready}, 1);
      check("rst e1", {31'd0, eject_1leu}, 0);
      check("rst e50", {31'd0, eject_50bani}, 0);
      check("rst done", {31'd0, done}, 0);
      check("rst short", {31'd0, short}, 0);
      check("rst remaining", {28'd0, remaining}, 0);
      rst_n = 1'b1;
      clear_busy();

      run_payout("full5", 5, 0, 0, 0);
      run_payout("no1leu3", 3, 1, 0, 0);
      run_payout("bothempty3", 3, 1, 1, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("held short", {31'd0, short}, 1);
      check("held remaining", {28'd0, remaining}, 3);
      run_payout("no50b3", 3, 0, 1, 0);

      busy[1] = 1'b1; busy[2] = 1'b1; busy[3] = 1'b1;
      run_payout("busy1", 1, 0, 0, 6);
      clear_busy();
      run_payout("zero", 0, 0, 0, 0);

      // Asynchronous reset in the middle of a 1-leu pulse
      empty_1leu = 1'b0; empty_50bani = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_amount = 4'd5;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("pre-reset e1", {31'd0, eject_1leu}, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async e1", {31'd0, eject_1leu}, 0);
      check("async e50", {31'd0, eject_50bani}, 0);
      check("async done", {31'd0, done}, 0);
      check("async remaining", {28'd0, remaining}, 0);
      check("async short", {31'd0, short}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1 check("post-reset ready", {31'd0, req_ready}, 1);

      // Randomized payouts with random stock and mechanism stalls
      for (int n = 0; n < 25; n++) begin
         for (int i = 0; i < NC; i++) busy[i] = (i < 400) && ($urandom_range(0, 3) == 0);
         run_payout($sformatf("rnd%0d", n), $urandom_range(0, 15),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/coin_payout.md
# coin_payout

Change/refund payout controller for the chocolate vending machine: the output-side counterpart of the coin-accepting credit FSM. It takes a payout request in 50-bani units and drives the coin-eject mechanism, releasing 1-leu coins first and then 50-bani coins, one coin per mechanism cycle. It reports completion and any amount it could not pay because the coin tubes ran empty.

## Interface
- AMT_W, default 4: width of amounts, in units of 50 bani (max payout (2^AMT_W−1)×50 bani).
- PULSE_LEN, default 4: cycles each eject pulse is held high; legal range 1..15.

- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  payout request present.
- req_amount  in  AMT_W  amount to pay, 50-bani units; sampled on accept.
- req_ready  out  1  high only in IDLE; accept = req_valid && req_ready on a rising edge.
- mech_busy  in  1  eject mechanism busy; no new pulse starts while high.
- empty_1leu  in  1  1-leu tube empty.
- empty_50bani  in  1  50-bani tube empty.
- eject_1leu  out  1  registered eject pulse, 1-leu coin.
- eject_50bani  out  1  registered eject pulse, 50-bani coin.
- done  out  1  one-cycle pulse, payout finished.
- short  out  1  valid with done; 1 = could not pay in full. Holds until next accept.
- remaining  out  AMT_W  unpaid amount; holds residual after done until next accept.

## Operation
- States: IDLE, SELECT, EJECT, SETTLE, DONE. Reset state IDLE.
- Reset values: req_ready=1 (IDLE), eject_1leu=0, eject_50bani=0, done=0, short=0, remaining=0, pulse counter=0.
- IDLE: on accept, remaining <= req_amount, short <= 0, go SELECT. req_valid ignored in all other states.
- SELECT (coin choice evaluated every cycle in this state, stock inputs sampled here):
  - remaining ≥ 2 and !empty_1leu -> coin = 1 leu.
  - else remaining ≥ 1 and !empty_50bani -> coin = 50 bani (includes remaining ≥ 2 with 1-leu tube empty).
  - else if remaining = 0 -> DONE, short <= 0.
  - else (remaining ≥ 1, no usable coin) -> DONE, short <= 1.
  - coin chosen and mech_busy=0: go EJECT, assert chosen eject output, remaining decremented by 2 (1 leu) or 1 (50 bani) on this same edge.
  - coin chosen and mech_busy=1: stay in SELECT, no output, re-evaluate next cycle (stock may change while waiting).
- EJECT: selected eject output held high for exactly PULSE_LEN cycles, then SETTLE. mech_busy and stock inputs ignored here.
- SETTLE: both eject outputs low for one cycle, then SELECT.
- DONE: done=1 for one cycle, then IDLE.
- eject_1leu and eject_50bani never high simultaneously.
- remaining is unsigned AMT_W; decrement by 2 only when remaining ≥ 2, so no wrap.
- Reset mid-operation (any state): all outputs to reset values immediately (asynchronous), eject pulse truncated, no done pulse, request discarded.

## Timing
- Accept on edge 0 -> SELECT in cycle 1.
- Mechanism free: eject high cycles 2..PULSE_LEN+1, SETTLE at PULSE_LEN+2, SELECT at PULSE_LEN+3.
- Per coin with mech free: PULSE_LEN+2 cycles.
- Last SELECT -> done high next cycle; req_ready high the cycle after done.
- Zero amount: accept edge 0, SELECT cycle 1, done cycle 2, req_ready cycle 3.
- Each cycle of mech_busy=1 in SELECT adds one cycle of delay.

## Test plan
- Reset: rst_n low mid-EJECT -> eject outputs, done, short, remaining drop to 0 immediately; req_ready=1 after release.
- Full payout, PULSE_LEN=4, req_amount=5, tubes full, mech_busy=0 -> eject_1leu cycles 2–5 and 8–11, eject_50bani cycles 14–17, done cycle 20 with short=0, remaining=0.
- 1-leu tube empty, req_amount=3 -> three eject_50bani pulses, no eject_1leu, done with short=0.
- Both tubes empty, req_amount=3 -> no ejects, done cycle 2, short=1, remaining=3 held until next accept.
- 50-bani tube empty, req_amount=3 -> one eject_1leu, then done, short=1, remaining=1.
- mech_busy held high 3 cycles from cycle 1, req_amount=1 -> eject_50bani starts cycle 5; req_valid pulsed during payout ignored; req_amount=0 -> done cycle 2, no ejects.
